// File: rtl/serial_sub_nbit_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// Optional feature macro used by the block: SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_sub_nbit_if.sv
// Handshake and operand/result bundle for serial_sub_nbit.
// SERIAL_SUB_OVF_EN adds the ovf result signal.
interface serial_sub_nbit_if #(parameter int n = 4);

   logic         in_valid;
   logic         in_ready;
   logic [n-1:0] x;
   logic [n-1:0] y;
   logic         bin;
   logic         out_valid;
   logic         out_ready;
   logic [n-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   modport master (
      output in_valid, x, y, bin, out_ready,
      input  in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, x, y, bin, out_ready,
      output in_ready, out_valid, diff, bout
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );

endinterface

// File: rtl/serial_sub_nbit_sub_bit_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module sub_bit_cell (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub_nbit.sv
// Bit-serial n-bit subtractor, LSB first, one sub_bit_cell plus a borrow flop.
// Optional: define SERIAL_SUB_OVF_EN to add the two's-complement ovf output.
module serial_sub_nbit
   import serial_sub_pkg::*;
#(
   parameter int n = 4
) (
   input logic             clk,
   input logic             rst_n,
   serial_sub_nbit_if.slave bus
);

   localparam int             CW   = clog2_min1(n);
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [n-1:0]   r_x;
   logic [n-1:0]   r_y;
   logic [n-1:0]   r_diff;
   logic [CW-1:0]  r_cnt;
   logic           r_borrow;
   logic           w_d;
   logic           w_b;
   logic           w_accept;
   logic           w_busy;
   logic           w_last;
   logic           w_in_ready;
   logic           w_out_valid;

   assign w_accept = (r_state == IDLE) && bus.in_valid;
   assign w_busy   = (r_state == BUSY);
   assign w_last   = w_busy && (r_cnt == LAST);

   sub_bit_cell u_cell (
      .x    (r_x[0]),
      .y    (r_y[0]),
      .bin  (r_borrow),
      .d    (w_d),
      .bout (w_b)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state decode and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) w_state_nxt = BUSY;
         end
         BUSY: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            w_out_valid = 1'b1;
            if (bus.out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand shift registers: loaded on accept, shifted right each BUSY cycle
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_x <= bus.x;
         r_y <= bus.y;
      end else if (w_busy) begin
         r_x <= r_x >> 1;
         r_y <= r_y >> 1;
      end
   end

   // Bit counter, borrow flop and difference shift register (result enters at the MSB)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_diff   <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_borrow <= bus.bin;
      end else if (w_busy) begin
         r_borrow <= w_b;
         r_diff   <= n'({w_d, r_diff} >> 1);
         r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic r_xs;
   logic r_ys;
   logic r_ovf;

   // Sign bits captured on accept; overflow latched as the final (sign) bit is produced
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xs  <= 1'b0;
         r_ys  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_xs <= bus.x[n-1];
         r_ys <= bus.y[n-1];
      end else if (w_last) begin
         r_ovf <= (r_xs != r_ys) && (w_d != r_xs);
      end
   end

   assign bus.ovf = r_ovf;
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.diff      = r_diff;
   assign bus.bout      = r_borrow;

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Self-checking bench for serial_sub_nbit: n=4 directed steps plus n=1 / n=8 sweeps.
// Honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_sub_nbit;

   typedef struct packed {
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   exp_t q[$];

   // Per-instance drive/observe arrays: index 0 -> n=4, 1 -> n=1, 2 -> n=8
   logic       iv[3];
   logic [7:0] xs[3];
   logic [7:0] ys[3];
   logic       bs[3];
   logic       ors[3];
   logic       rdy[3];
   logic       ov[3];
   logic [7:0] dg[3];
   logic       bo[3];
   logic       og[3];

   serial_sub_nbit_if #(.n(4)) bus4 ();
   serial_sub_nbit_if #(.n(1)) bus1 ();
   serial_sub_nbit_if #(.n(8)) bus8 ();

   serial_sub_nbit #(.n(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
   serial_sub_nbit #(.n(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   serial_sub_nbit #(.n(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

   assign bus4.in_valid = iv[0];  assign bus4.x = xs[0][3:0]; assign bus4.y = ys[0][3:0];
   assign bus4.bin = bs[0];       assign bus4.out_ready = ors[0];
   assign bus1.in_valid = iv[1];  assign bus1.x = xs[1][0:0]; assign bus1.y = ys[1][0:0];
   assign bus1.bin = bs[1];       assign bus1.out_ready = ors[1];
   assign bus8.in_valid = iv[2];  assign bus8.x = xs[2];      assign bus8.y = ys[2];
   assign bus8.bin = bs[2];       assign bus8.out_ready = ors[2];

   assign rdy[0] = bus4.in_ready; assign ov[0] = bus4.out_valid;
   assign dg[0]  = {4'h0, bus4.diff}; assign bo[0] = bus4.bout;
   assign rdy[1] = bus1.in_ready; assign ov[1] = bus1.out_valid;
   assign dg[1]  = {7'h0, bus1.diff}; assign bo[1] = bus1.bout;
   assign rdy[2] = bus8.in_ready; assign ov[2] = bus8.out_valid;
   assign dg[2]  = bus8.diff;         assign bo[2] = bus8.bout;
`ifdef SERIAL_SUB_OVF_EN
   assign og[0] = bus4.ovf; assign og[1] = bus1.ovf; assign og[2] = bus8.ovf;
`else
   assign og[0] = 1'b0; assign og[1] = 1'b0; assign og[2] = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int width_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
   endfunction

   function automatic exp_t mk(input logic [7:0] d, input logic b, input logic o);
      exp_t e;
      e.diff = d; e.bout = b; e.ovf = o;
      return e;
   endfunction

   // Arithmetic reference: whole-word subtraction, not bit-serial
   function automatic exp_t model(input int w, input int xv, input int yv, input int bv);
      int mask, dv, xsg, ysg, dsg;
      mask = (1 << w) - 1;
      dv   = (xv - yv - bv) & mask;
      xsg  = (xv >> (w - 1)) & 1;
      ysg  = (yv >> (w - 1)) & 1;
      dsg  = (dv >> (w - 1)) & 1;
      return mk(8'(dv), (xv < yv + bv), (xsg != ysg) && (dsg != xsg));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Wait (bounded) for in_ready, present operands for exactly one accepting edge
   task automatic send(input int k, input logic [7:0] xv, input logic [7:0] yv,
                       input logic bv, input exp_t e);
      int g;
      g = 0;
      while (!rdy[k] && g < 40) begin @(negedge clk); g++; end
      chk("in_ready_before_send", 32'(rdy[k]), 32'd1);
      iv[k] = 1'b1; xs[k] = xv; ys[k] = yv; bs[k] = bv;
      @(negedge clk);
      iv[k] = 1'b0;
      q.push_back(e);
   endtask

   // Count negedges until out_valid; must equal the expected remaining latency
   task automatic wait_valid(input int k, input int lat);
      int c;
      c = 0;
      while (!ov[k] && c < 60) begin @(negedge clk); c++; end
      chk("out_valid_latency", 32'(c), 32'(lat));
   endtask

   // Compare against the scoreboard head, then complete the output handshake
   task automatic recv(input int k);
      exp_t e;
      chk("scoreboard_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("diff", 32'(dg[k]), 32'(e.diff));
         chk("bout", 32'(bo[k]), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
         chk("ovf", 32'(og[k]), 32'(e.ovf));
`endif
      end
      ors[k] = 1'b1;
      @(negedge clk);
      ors[k] = 1'b0;
      iv[k]  = 1'b0;
      chk("in_ready_after_handshake", 32'(rdy[k]), 32'd1);
      chk("out_valid_after_handshake", 32'(ov[k]), 32'd0);
   endtask

   initial begin
      exp_t e;
      n_tests = 0;
      n_fail  = 0;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; xs[k] = '0; ys[k] = '0; bs[k] = 1'b0; ors[k] = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("reset_in_ready", 32'(rdy[0]), 32'd1);
      chk("reset_out_valid", 32'(ov[0]), 32'd0);
      chk("reset_diff", 32'(dg[0]), 32'd0);
      chk("reset_bout", 32'(bo[0]), 32'd0);
      chk("reset_ovf", 32'(og[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic subtractions
      send(0, 8'd9, 8'd3, 1'b0, mk(8'h6, 1'b0, 1'b1));  wait_valid(0, 4); recv(0);
      send(0, 8'd3, 8'd9, 1'b0, mk(8'hA, 1'b1, 1'b1));  wait_valid(0, 4); recv(0);
      send(0, 8'd0, 8'd0, 1'b1, mk(8'hF, 1'b1, 1'b0));  wait_valid(0, 4); recv(0);

      // Back-pressure: result held for 5 cycles with out_ready low
      send(0, 8'hE, 8'h2, 1'b0, mk(8'hC, 1'b0, 1'b0));
      wait_valid(0, 4);
      e = q[0];
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_out_valid", 32'(ov[0]), 32'd1);
         chk("hold_in_ready", 32'(rdy[0]), 32'd0);
         chk("hold_diff", 32'(dg[0]), 32'(e.diff));
         chk("hold_bout", 32'(bo[0]), 32'(e.bout));
      end
      recv(0);

      // Inputs wiggled during BUSY and in_valid held high through DONE
      send(0, 8'hC, 8'h5, 1'b1, mk(8'h6, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++) begin
         iv[0] = i[0] ? 1'b0 : 1'b1;
         xs[0] = 8'($urandom); ys[0] = 8'($urandom); bs[0] = 1'($urandom);
         @(negedge clk);
      end
      iv[0] = 1'b1;
      wait_valid(0, 1);
      chk("done_in_ready_low", 32'(rdy[0]), 32'd0);
      recv(0);
      chk("no_extra_accept", 32'(q.size()), 32'd0);

      // Reset asserted mid-operation at bit 2
      send(0, 8'h0, 8'h1, 1'b0, mk(8'hF, 1'b1, 1'b0));
      repeat (2) @(negedge clk);
      chk("busy_partial_borrow", 32'(bo[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      void'(q.pop_front());
      chk("abort_out_valid", 32'(ov[0]), 32'd0);
      chk("abort_diff", 32'(dg[0]), 32'd0);
      chk("abort_bout", 32'(bo[0]), 32'd0);
      chk("abort_in_ready", 32'(rdy[0]), 32'd1);
      chk("abort_ovf", 32'(og[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_partial_result", 32'(ov[0]), 32'd0);
      end
      send(0, 8'd5, 8'd5, 1'b0, mk(8'h0, 1'b0, 1'b0));  wait_valid(0, 4); recv(0);

      // Signed overflow corners (diff/bout always checked)
      send(0, 8'h7, 8'h8, 1'b0, mk(8'hF, 1'b1, 1'b1));  wait_valid(0, 4); recv(0);
      send(0, 8'h8, 8'h1, 1'b0, mk(8'h7, 1'b0, 1'b1));  wait_valid(0, 4); recv(0);
      send(0, 8'h2, 8'h1, 1'b0, mk(8'h1, 1'b0, 1'b0));  wait_valid(0, 4); recv(0);

      // Sweeps at n=1 and n=8 against the arithmetic model
      for (int k = 1; k < 3; k++) begin
         int w, xv, yv, bv, mask;
         w    = width_of(k);
         mask = (1 << w) - 1;
         send(k, 8'(mask >> 1), 8'(mask >> 1), 1'b1, model(w, mask >> 1, mask >> 1, 1));
         wait_valid(k, w);
         recv(k);
         for (int t = 0; t < 16; t++) begin
            xv = int'($urandom) & mask;
            yv = int'($urandom) & mask;
            bv = int'($urandom_range(0, 1));
            send(k, 8'(xv), 8'(yv), 1'(bv), model(w, xv, yv, bv));
            wait_valid(k, w);
            recv(k);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
